// File: rtl/bcd_up_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_up_counter_if
// Bundles the counter's control inputs and display outputs so that the
// button/divider side and the counter can be connected as a single port.
//   i_tick_clk  : slow clock from the divider (asynchronous level)
//   i_btn_run   : one-cycle pulse, toggles RUN/STOP
//   i_btn_clear : one-cycle pulse, clears the count while stopped
//   o_bcd       : packed BCD count, digit 0 (ones) in bits [3:0]
//   o_running   : high while the counter is in RUN
//   o_wrap      : one-cycle pulse on roll-over from all 9s to 0
// Modports: master = stimulus/button side, slave = counter.
// ---------------------------------------------------------------------------
interface bcd_up_counter_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    i_tick_clk;
    logic                    i_btn_run;
    logic                    i_btn_clear;
    logic [4*NUM_DIGITS-1:0] o_bcd;
    logic                    o_running;
    logic                    o_wrap;

    modport master (
        output i_tick_clk, i_btn_run, i_btn_clear,
        input  o_bcd, o_running, o_wrap
    );

    modport slave (
        input  i_tick_clk, i_btn_run, i_btn_clear,
        output o_bcd, o_running, o_wrap
    );
endinterface

// File: rtl/bcd_up_counter.sv
// ---------------------------------------------------------------------------
// bcd_up_counter
// Run/stop/clear multi-digit BCD up-counter advanced by rising edges of a
// slow divider clock. Everything runs in the i_clk domain; the slow clock is
// synchronised and edge-detected before it is used.
//   i_clk   : system clock
//   i_reset : asynchronous, active-high reset
//   bus     : bcd_up_counter_if.slave (tick input, buttons, count outputs)
// A slow-clock rising edge seen before i_clk edge k updates o_bcd at edge k+2.
// ---------------------------------------------------------------------------

// One BCD digit of the increment chain: passes the digit through without a
// carry-in, otherwise steps 0..9 and rolls 9 -> 0 with a carry-out.
module bcd_digit (
    input  logic [3:0] d,
    input  logic       cin,
    output logic [3:0] nxt,
    output logic       cout
);
    logic is_nine;
    assign is_nine = (d == 4'd9);
    assign cout    = cin & is_nine;
    assign nxt     = !cin   ? d :
                     is_nine ? 4'd0 : 4'(d + 4'd1);
endmodule

module bcd_up_counter #(
    parameter int NUM_DIGITS = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    bcd_up_counter_if.slave   bus
);
    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t state;
    logic   running;
    logic   wrap;

    logic [NUM_DIGITS-1:0][3:0] bcd_q;
    logic [NUM_DIGITS-1:0][3:0] bcd_nxt;
    logic [NUM_DIGITS:0]        carry;

    // Slow-clock synchroniser: sync0/sync1 resolve metastability, sync2 holds
    // the previous synchronised level for rising-edge detection.
    logic sync0, sync1, sync2;
    logic tick;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync0 <= bus.i_tick_clk;
            sync1 <= sync0;
            sync2 <= sync1;
        end
    end

    assign tick = sync1 & ~sync2;

    // Run/stop/clear control. o_running is registered alongside the state so
    // it always equals (state == RUN) with no combinational input path.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= STOP;
            running <= 1'b0;
        end else begin
            case (state)
                STOP: begin
                    // Clear has priority over a simultaneous run pulse.
                    if (bus.i_btn_clear) begin
                        state   <= CLEAR;
                        running <= 1'b0;
                    end else if (bus.i_btn_run) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.i_btn_run) begin
                        state   <= STOP;
                        running <= 1'b0;
                    end
                end
                CLEAR: begin
                    state   <= STOP;
                    running <= 1'b0;
                end
                default: begin
                    state   <= STOP;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Ripple-carry BCD increment; digit 0 always receives the carry-in.
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .d    (bcd_q[g]),
            .cin  (carry[g]),
            .nxt  (bcd_nxt[g]),
            .cout (carry[g+1])
        );
    end

    // Counting keys off the current state, so a tick on the edge that leaves
    // RUN is still counted and one on the edge that enters RUN is not.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bcd_q <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (state == CLEAR) begin
                bcd_q <= '0;
            end else if (state == RUN && tick) begin
                bcd_q <= bcd_nxt;
                wrap  <= carry[NUM_DIGITS];
            end
        end
    end

    assign bus.o_bcd     = bcd_q;
    assign bus.o_running = running;
    assign bus.o_wrap    = wrap;
endmodule

// File: tb/tb_bcd_up_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_up_counter
// Directed bench for bcd_up_counter (NUM_DIGITS = 4). Inputs change on the
// falling edge of i_clk and outputs are sampled on the falling edge, half a
// cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_bcd_up_counter;
    localparam int ND = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vecs  = 0;
    int   errs  = 0;

    bcd_up_counter_if #(.NUM_DIGITS(ND)) bus ();

    bcd_up_counter #(.NUM_DIGITS(ND)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_run();
        bus.i_btn_run = 1'b1;
        @(negedge clk);
        bus.i_btn_run = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.i_btn_clear = 1'b1;
        @(negedge clk);
        bus.i_btn_clear = 1'b0;
    endtask

    // n slow-clock periods, hi cycles high then lo cycles low.
    task automatic tick_n(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            bus.i_tick_clk = 1'b1;
            repeat (hi) @(negedge clk);
            bus.i_tick_clk = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    // One slow tick with the count and wrap pulse checked in the exact cycle
    // the update lands (two edges after the rise), then wrap checked low.
    task automatic tick_chk(input string tag, input logic [15:0] exp_bcd, input logic exp_wrap);
        bus.i_tick_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_bcd"}, bus.o_bcd, exp_bcd);
        chk({tag, "_wrap"}, 16'(bus.o_wrap), 16'(exp_wrap));
        bus.i_tick_clk = 1'b0;
        @(negedge clk);
        chk({tag, "_wrap_after"}, 16'(bus.o_wrap), 16'h0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.i_tick_clk  = 1'b0;
        bus.i_btn_run   = 1'b0;
        bus.i_btn_clear = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bcd", bus.o_bcd, 16'h0000);
        chk("rst_running", 16'(bus.o_running), 16'h0);
        chk("rst_wrap", 16'(bus.o_wrap), 16'h0);
        reset = 1'b0;
        @(negedge clk);

        // 1: run, then 12 slow ticks (period 200) with latency check on the first
        pulse_run();
        chk("t1_running", 16'(bus.o_running), 16'h1);
        bus.i_tick_clk = 1'b1;
        @(negedge clk);
        chk("t1_lat_k", bus.o_bcd, 16'h0000);
        @(negedge clk);
        chk("t1_lat_k1", bus.o_bcd, 16'h0000);
        @(negedge clk);
        chk("t1_lat_k2", bus.o_bcd, 16'h0001);
        repeat (97) @(negedge clk);
        bus.i_tick_clk = 1'b0;
        repeat (100) @(negedge clk);
        tick_n(11, 100, 100);
        chk("t1_bcd12", bus.o_bcd, 16'h0012);
        chk("t1_running_end", 16'(bus.o_running), 16'h1);

        // 2: stop, ticks ignored, then clear in STOP
        pulse_run();
        chk("t2_stopped", 16'(bus.o_running), 16'h0);
        tick_n(5, 2, 2);
        chk("t2_frozen", bus.o_bcd, 16'h0012);
        pulse_clear();
        chk("t2_clear_e", bus.o_bcd, 16'h0012);
        @(negedge clk);
        chk("t2_clear_e1", bus.o_bcd, 16'h0000);
        chk("t2_clear_running", 16'(bus.o_running), 16'h0);
        tick_n(2, 2, 2);
        chk("t2_stop_after_clear", bus.o_bcd, 16'h0000);

        // 3: digit carries 0009->0010, 0099->0100
        pulse_run();
        tick_n(9, 2, 2);
        chk("t3_0009", bus.o_bcd, 16'h0009);
        tick_chk("t3_0010", 16'h0010, 1'b0);
        tick_n(89, 2, 2);
        chk("t3_0099", bus.o_bcd, 16'h0099);
        tick_chk("t3_0100", 16'h0100, 1'b0);

        // 4a: clear ignored in RUN
        tick_n(245, 2, 2);
        chk("t4_0345", bus.o_bcd, 16'h0345);
        pulse_clear();
        @(negedge clk);
        chk("t4_clr_ign_bcd", bus.o_bcd, 16'h0345);
        chk("t4_clr_ign_run", 16'(bus.o_running), 16'h1);
        tick_chk("t4_0346", 16'h0346, 1'b0);

        // 3 (cont.): 9999 -> 0000 with a single-cycle wrap pulse
        tick_n(9653, 2, 2);
        chk("t3_9999", bus.o_bcd, 16'h9999);
        tick_chk("t3_wrap", 16'h0000, 1'b1);
        tick_n(5, 2, 2);
        chk("t3_after_wrap", bus.o_bcd, 16'h0005);

        // 4b: simultaneous run+clear in STOP -> clear wins
        pulse_run();
        chk("t4_stop", 16'(bus.o_running), 16'h0);
        bus.i_btn_run   = 1'b1;
        bus.i_btn_clear = 1'b1;
        @(negedge clk);
        bus.i_btn_run   = 1'b0;
        bus.i_btn_clear = 1'b0;
        chk("t4_both_running", 16'(bus.o_running), 16'h0);
        @(negedge clk);
        chk("t4_both_bcd", bus.o_bcd, 16'h0000);
        chk("t4_both_running2", 16'(bus.o_running), 16'h0);
        tick_n(2, 2, 2);
        chk("t4_both_still_stop", bus.o_bcd, 16'h0000);

        // 5a: tick on the same edge as STOP->RUN is not counted
        bus.i_tick_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.i_btn_run = 1'b1;
        @(negedge clk);
        bus.i_btn_run = 1'b0;
        chk("t5_enter_run", 16'(bus.o_running), 16'h1);
        chk("t5_enter_bcd", bus.o_bcd, 16'h0000);
        bus.i_tick_clk = 1'b0;
        repeat (3) @(negedge clk);
        tick_n(3, 2, 2);
        chk("t5_0003", bus.o_bcd, 16'h0003);

        // 5b: tick on the same edge as RUN->STOP is counted, then frozen
        bus.i_tick_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.i_btn_run = 1'b1;
        @(negedge clk);
        bus.i_btn_run = 1'b0;
        chk("t5_leave_run", 16'(bus.o_running), 16'h0);
        chk("t5_leave_bcd", bus.o_bcd, 16'h0004);
        bus.i_tick_clk = 1'b0;
        repeat (3) @(negedge clk);
        tick_n(2, 2, 2);
        chk("t5_frozen", bus.o_bcd, 16'h0004);

        // 6: async reset mid slow-clock high at 0777
        pulse_run();
        tick_n(772, 2, 2);
        chk("t6_0776", bus.o_bcd, 16'h0776);
        bus.i_tick_clk = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_0777", bus.o_bcd, 16'h0777);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_bcd", bus.o_bcd, 16'h0000);
        chk("t6_async_running", 16'(bus.o_running), 16'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_release_bcd", bus.o_bcd, 16'h0000);
        chk("t6_release_running", 16'(bus.o_running), 16'h0);
        bus.i_tick_clk = 1'b0;
        repeat (3) @(negedge clk);
        tick_n(3, 2, 2);
        chk("t6_no_count", bus.o_bcd, 16'h0000);
        pulse_run();
        tick_chk("t6_rerun", 16'h0001, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
